// File: rtl/fft_pkg.sv
// Shared constants and FSM encoding for the radix-2 FFT sequencer family.
package fft_pkg;

    localparam int DW_DEF    = 18;
    localparam int LOG2N_DEF = 3;
    localparam int ROM_LAT   = 1;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_RDW  = 3'd2,
        ST_BF   = 3'd3,
        ST_WR0  = 3'd4,
        ST_WR1  = 3'd5,
        ST_CLR  = 3'd6,
        ST_DONE = 3'd7
    } fft_state_e;

endpackage

// File: rtl/fft_addr_gen.sv
// Combinational in-place DIT addressing: (stage, butterfly) -> (upper leg, lower leg, twiddle index).
module fft_addr_gen #(
    parameter int LOG2N = 3
) (
    input  logic [LOG2N-1:0] s,
    input  logic [LOG2N-2:0] j,
    output logic [LOG2N-1:0] a,
    output logic [LOG2N-1:0] b,
    output logic [LOG2N-2:0] tw
);

    localparam logic [LOG2N-1:0] ONE = LOG2N'(1);
    localparam logic [LOG2N-1:0] TOP = LOG2N'(LOG2N - 1);

    logic [LOG2N-1:0] jx;
    logic [LOG2N-1:0] half;
    logic [LOG2N-1:0] k;

    always_comb begin
        jx   = {1'b0, j};
        half = ONE << s;
        k    = jx & (half - ONE);
        // Group base: drop the low s bits of j, then leave a gap of 'half' for the lower legs.
        a    = ((jx >> s) << (s + ONE)) | k;
        b    = a | half;
        tw   = (LOG2N-1)'(k << (TOP - s));
    end

endmodule

// File: rtl/fft_r2_sched.sv
// Sequencer for an in-place radix-2 DIT FFT around one shared butterfly unit.
// Handshake: bf_start is a level held only in BF; the butterfly answers with bf_done, which must fall in CLR before the next butterfly.
module fft_r2_sched
    import fft_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int LOG2N = LOG2N_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [LOG2N-1:0] stage_o,
    output logic [LOG2N-1:0] mem_raddr_a,
    output logic [LOG2N-1:0] mem_raddr_b,
    input  logic [DW-1:0]    mem_rd_a_r,
    input  logic [DW-1:0]    mem_rd_a_i,
    input  logic [DW-1:0]    mem_rd_b_r,
    input  logic [DW-1:0]    mem_rd_b_i,
    output logic [LOG2N-2:0] tw_addr,
    output logic [DW-1:0]    bf_in0_r,
    output logic [DW-1:0]    bf_in0_i,
    output logic [DW-1:0]    bf_in1_r,
    output logic [DW-1:0]    bf_in1_i,
    output logic             bf_start,
    input  logic             bf_done,
    input  logic [DW:0]      bf_out0_r,
    input  logic [DW:0]      bf_out0_i,
    input  logic [DW:0]      bf_out1_r,
    input  logic [DW:0]      bf_out1_i,
    output logic             mem_we,
    output logic [LOG2N-1:0] mem_waddr,
    output logic [DW-1:0]    mem_wd_r,
    output logic [DW-1:0]    mem_wd_i,
    output fft_state_e       state_o
);

    localparam logic [LOG2N-1:0] S_LAST = LOG2N'(LOG2N - 1);
    localparam logic [LOG2N-2:0] J_LAST = '1;

    fft_state_e       state_q, state_d;
    logic [LOG2N-1:0] s_q, s_d;
    logic [LOG2N-2:0] j_q, j_d;
    logic [DW-1:0]    in0_r_q, in0_r_d, in0_i_q, in0_i_d;
    logic [DW-1:0]    in1_r_q, in1_r_d, in1_i_q, in1_i_d;

    logic [LOG2N-1:0] addr_a, addr_b;
    logic [LOG2N-2:0] addr_tw;
    logic             run;
    logic             unused_lsb;

    fft_addr_gen #(.LOG2N(LOG2N)) u_addr (
        .s  (s_q),
        .j  (j_q),
        .a  (addr_a),
        .b  (addr_b),
        .tw (addr_tw)
    );

    // The floor-halving write drops the butterfly LSB.
    assign unused_lsb = ^{bf_out0_r[0], bf_out0_i[0], bf_out1_r[0], bf_out1_i[0]};

    assign run      = state_q inside {ST_RD, ST_RDW, ST_BF, ST_WR0, ST_WR1, ST_CLR};
    assign stage_o  = s_q;
    assign state_o  = state_q;
    assign bf_in0_r = in0_r_q;
    assign bf_in0_i = in0_i_q;
    assign bf_in1_r = in1_r_q;
    assign bf_in1_i = in1_i_q;

    always_comb begin
        state_d     = state_q;
        s_d         = s_q;
        j_d         = j_q;
        in0_r_d     = in0_r_q;
        in0_i_d     = in0_i_q;
        in1_r_d     = in1_r_q;
        in1_i_d     = in1_i_q;
        busy        = run;
        done        = 1'b0;
        bf_start    = 1'b0;
        mem_we      = 1'b0;
        mem_waddr   = '0;
        mem_wd_r    = '0;
        mem_wd_i    = '0;
        mem_raddr_a = '0;
        mem_raddr_b = '0;
        tw_addr     = run ? addr_tw : '0;

        case (state_q)
            ST_IDLE: if (start) state_d = ST_RD;
            ST_RD: begin
                mem_raddr_a = addr_a;
                mem_raddr_b = addr_b;
                state_d     = ST_RDW;
            end
            ST_RDW: begin
                in0_r_d = mem_rd_a_r;
                in0_i_d = mem_rd_a_i;
                in1_r_d = mem_rd_b_r;
                in1_i_d = mem_rd_b_i;
                state_d = ST_BF;
            end
            ST_BF: begin
                bf_start = 1'b1;
                if (bf_done) state_d = ST_WR0;
            end
            ST_WR0: begin
                mem_we    = 1'b1;
                mem_waddr = addr_a;
                mem_wd_r  = bf_out0_r[DW:1];
                mem_wd_i  = bf_out0_i[DW:1];
                state_d   = ST_WR1;
            end
            ST_WR1: begin
                mem_we    = 1'b1;
                mem_waddr = addr_b;
                mem_wd_r  = bf_out1_r[DW:1];
                mem_wd_i  = bf_out1_i[DW:1];
                state_d   = ST_CLR;
            end
            ST_CLR: begin
                if (!bf_done) begin
                    state_d = ST_RD;
                    if (j_q == J_LAST) begin
                        j_d = '0;
                        if (s_q == S_LAST) begin
                            s_d     = '0;
                            state_d = ST_DONE;
                        end else begin
                            s_d = s_q + LOG2N'(1);
                        end
                    end else begin
                        j_d = j_q + (LOG2N-1)'(1);
                    end
                end
            end
            ST_DONE: begin
                done = 1'b1;
                if (!start) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Dropping start mid-run abandons the transform within the same cycle.
        if (run && !start) begin
            state_d   = ST_IDLE;
            s_d       = '0;
            j_d       = '0;
            busy      = 1'b0;
            bf_start  = 1'b0;
            mem_we    = 1'b0;
            mem_waddr = '0;
            mem_wd_r  = '0;
            mem_wd_i  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            s_q     <= '0;
            j_q     <= '0;
            in0_r_q <= '0;
            in0_i_q <= '0;
            in1_r_q <= '0;
            in1_i_q <= '0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            j_q     <= j_d;
            in0_r_q <= in0_r_d;
            in0_i_q <= in0_i_d;
            in1_r_q <= in1_r_d;
            in1_i_q <= in1_i_d;
        end
    end

endmodule

// File: tb/tb_fft_r2_sched.sv
// Directed bench for fft_r2_sched with RAM, twiddle ROM and a one-register butterfly model.
module tb_fft_r2_sched;
    import fft_pkg::*;

    localparam int DW    = 18;
    localparam int LOG2N = 3;
    localparam int NPT   = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
    logic busy, done, bf_start, bf_done, mem_we;
    logic [2:0] stage_o, mem_raddr_a, mem_raddr_b, mem_waddr;
    logic [1:0] tw_addr;
    logic signed [DW-1:0] rd_a_r, rd_a_i, rd_b_r, rd_b_i;
    logic signed [DW-1:0] bf_in0_r, bf_in0_i, bf_in1_r, bf_in1_i;
    logic signed [DW:0]   bf_out0_r, bf_out0_i, bf_out1_r, bf_out1_i;
    logic signed [DW-1:0] mem_wd_r, mem_wd_i;
    fft_state_e state_o;

    // RAM, ROM and butterfly models
    logic signed [DW-1:0] ram_r [NPT];
    logic signed [DW-1:0] ram_i [NPT];
    logic                 ld_en = 1'b0;
    logic [2:0]           ld_addr = '0;
    logic signed [DW-1:0] ld_r = '0;
    longint               rom_r, rom_i;
    logic                 bf_done_m;
    logic                 inj_done = 1'b0;
    logic                 ovr = 1'b0;
    longint               pr, pi, wr_v, wi_v;

    int n_checks = 0;
    int n_errors = 0;
    logic        trace_en = 1'b0;
    logic [10:0] exp_q[$];
    logic [10:0] trace_e;
    int tr_a [12];
    int tr_b [12];
    int tr_t [12];

    fft_r2_sched #(.DW(DW), .LOG2N(LOG2N)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .stage_o(stage_o), .mem_raddr_a(mem_raddr_a), .mem_raddr_b(mem_raddr_b),
        .mem_rd_a_r(rd_a_r), .mem_rd_a_i(rd_a_i), .mem_rd_b_r(rd_b_r), .mem_rd_b_i(rd_b_i),
        .tw_addr(tw_addr),
        .bf_in0_r(bf_in0_r), .bf_in0_i(bf_in0_i), .bf_in1_r(bf_in1_r), .bf_in1_i(bf_in1_i),
        .bf_start(bf_start), .bf_done(bf_done),
        .bf_out0_r(bf_out0_r), .bf_out0_i(bf_out0_i), .bf_out1_r(bf_out1_r), .bf_out1_i(bf_out1_i),
        .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wd_r(mem_wd_r), .mem_wd_i(mem_wd_i),
        .state_o(state_o)
    );

    // clock / reset
    always #5 clk = ~clk;

    function automatic longint tw_re(input logic [1:0] t);
        case (t)
            2'd0: return 65536;
            2'd1: return 46341;
            2'd2: return 0;
            default: return -46341;
        endcase
    endfunction

    function automatic longint tw_im(input logic [1:0] t);
        case (t)
            2'd0: return 0;
            2'd1: return -46341;
            2'd2: return -65536;
            default: return -46341;
        endcase
    endfunction

    always @(posedge clk) begin
        if (ld_en) begin
            ram_r[ld_addr] <= ld_r;
            ram_i[ld_addr] <= '0;
        end else if (mem_we) begin
            ram_r[mem_waddr] <= mem_wd_r;
            ram_i[mem_waddr] <= mem_wd_i;
        end
        rd_a_r <= ram_r[mem_raddr_a];
        rd_a_i <= ram_i[mem_raddr_a];
        rd_b_r <= ram_r[mem_raddr_b];
        rd_b_i <= ram_i[mem_raddr_b];
        rom_r  <= tw_re(tw_addr);
        rom_i  <= tw_im(tw_addr);
    end

    always @(posedge clk or negedge rst) begin
        if (!rst) bf_done_m <= 1'b0;
        else      bf_done_m <= bf_start;
    end
    assign bf_done = bf_done_m | inj_done;

    always_comb begin
        wr_v = rom_r;
        wi_v = rom_i;
        pr = (longint'(bf_in1_r) * wr_v - longint'(bf_in1_i) * wi_v) >>> 16;
        pi = (longint'(bf_in1_r) * wi_v + longint'(bf_in1_i) * wr_v) >>> 16;
        bf_out0_r = 19'(longint'(bf_in0_r) + pr);
        bf_out0_i = 19'(longint'(bf_in0_i) + pi);
        bf_out1_r = 19'(longint'(bf_in0_r) - pr);
        bf_out1_i = 19'(longint'(bf_in0_i) - pi);
        if (ovr) begin
            bf_out0_r = -19'sd3;
            bf_out1_r = 19'sd3;
        end
    end

    task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // scoreboard for the read-address trace
    always @(posedge clk) begin
        #1;
        if (trace_en && state_o == ST_RD) begin
            if (exp_q.size() == 0) begin
                check("trace_extra", 1, 0);
            end else begin
                trace_e = exp_q.pop_front();
                check("trace", {stage_o, mem_raddr_a, mem_raddr_b, tw_addr}, trace_e);
            end
        end
    end

    // driver tasks
    // kind: 0 impulse, 1 dc, 2 alternating +/-800 (stored bit-reversed), 3 zeros
    task automatic load_ram(input int kind);
        for (int i = 0; i < NPT; i++) begin
            @(negedge clk);
            ld_en   = 1'b1;
            ld_addr = 3'(i);
            case (kind)
                0: ld_r = (i == 0) ? 18'sd1000 : 18'sd0;
                1: ld_r = 18'sd800;
                2: ld_r = (i < 4) ? 18'sd800 : -18'sd800;
                default: ld_r = 18'sd0;
            endcase
        end
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    task automatic run_fft(input int exp_cycles);
        int cyc;
        cyc = 0;
        @(negedge clk);
        start = 1'b1;
        while (!done && cyc < 400) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("run_done", done, 1);
        check("run_busy_low", busy, 0);
        if (exp_cycles > 0) check("run_cycles", cyc, exp_cycles);
        @(negedge clk);
        check("done_held", done, 1);
        start = 1'b0;
        @(posedge clk);
        #1;
        check("done_clear", done, 0);
        check("idle_after_done", state_o, ST_IDLE);
    endtask

    task automatic check_bins(input string tag, input int kind);
        int exp_r;
        for (int i = 0; i < NPT; i++) begin
            case (kind)
                0: exp_r = 125;
                1: exp_r = (i == 0) ? 800 : 0;
                default: exp_r = (i == 4) ? 800 : 0;
            endcase
            check($sformatf("%s_re%0d", tag, i), ram_r[i], exp_r);
            check($sformatf("%s_im%0d", tag, i), ram_i[i], 0);
        end
    endtask

    task automatic wait_state(input fft_state_e st);
        int cyc;
        cyc = 0;
        while (state_o != st && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("wait_state", state_o, st);
    endtask

    initial begin
        int cyc;
        tr_a = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
        tr_b = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
        tr_t = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};

        // reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_state", state_o, ST_IDLE);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_stage", stage_o, 0);
        check("rst_raddr_b", mem_raddr_b, 0);
        check("rst_bf_start", bf_start, 0);
        check("rst_we", mem_we, 0);
        @(negedge clk);
        rst = 1'b1;

        // impulse
        load_ram(0);
        run_fft(85);
        check_bins("imp", 0);

        // dc with address trace
        load_ram(1);
        for (int i = 0; i < 12; i++)
            exp_q.push_back({3'(i / 4), 3'(tr_a[i]), 3'(tr_b[i]), 2'(tr_t[i])});
        trace_en = 1'b1;
        run_fft(85);
        trace_en = 1'b0;
        check("trace_left", exp_q.size(), 0);
        check_bins("dc", 1);

        // floor halving on write-back, then abort during WR1
        load_ram(3);
        ovr = 1'b1;
        @(negedge clk);
        start = 1'b1;
        cyc = 0;
        while (!mem_we && cyc < 50) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("wr0_we", mem_we, 1);
        check("wr0_addr", mem_waddr, 0);
        check("round_neg", mem_wd_r, -2);
        @(posedge clk);
        #1;
        check("wr1_addr", mem_waddr, 1);
        check("round_pos", mem_wd_r, 1);
        @(negedge clk);
        start = 1'b0;
        #1;
        check("abort_wr_we", mem_we, 0);
        check("abort_wr_busy", busy, 0);
        @(posedge clk);
        #1;
        check("abort_wr_idle", state_o, ST_IDLE);
        ovr = 1'b0;

        // abort at s=1, j=2 during BF, then a clean restart
        load_ram(2);
        @(negedge clk);
        start = 1'b1;
        cyc = 0;
        while (!(state_o == ST_RD && stage_o == 3'd1 && mem_raddr_a == 3'd4) && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("abort_found", mem_raddr_b, 6);
        @(posedge clk);
        @(posedge clk);
        #1;
        check("abort_in_bf", state_o, ST_BF);
        check("abort_bf_start_pre", bf_start, 1);
        start = 1'b0;
        #1;
        check("abort_bf_start", bf_start, 0);
        check("abort_busy", busy, 0);
        check("abort_we", mem_we, 0);
        @(posedge clk);
        #1;
        check("abort_idle", state_o, ST_IDLE);
        check("abort_stage", stage_o, 0);
        load_ram(2);
        run_fft(85);
        check_bins("alt", 2);

        // bf_done while in CLR is not a handshake
        load_ram(0);
        @(negedge clk);
        start = 1'b1;
        wait_state(ST_CLR);
        inj_done = 1'b1;
        @(posedge clk);
        #1;
        check("clr_hold", state_o, ST_CLR);
        check("clr_we", mem_we, 0);
        check("clr_stage", stage_o, 0);
        inj_done = 1'b0;
        @(posedge clk);
        #1;
        check("clr_next_rd", state_o, ST_RD);
        check("clr_next_a", mem_raddr_a, 2);
        check("clr_next_b", mem_raddr_b, 3);

        // asynchronous reset in the middle of BF
        wait_state(ST_BF);
        #2;
        rst = 1'b0;
        #1;
        check("arst_state", state_o, ST_IDLE);
        check("arst_busy", busy, 0);
        check("arst_bf_start", bf_start, 0);
        check("arst_raddr_a", mem_raddr_a, 0);
        check("arst_tw", tw_addr, 0);
        check("arst_bf_in0", bf_in0_r, 0);
        @(negedge clk);
        start = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("arst_stays_idle", state_o, ST_IDLE);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
